// File: rtl/right_shifter.sv
// Right-shift register / serializer: loads a WIDTH-bit word and shifts it out
// LSB-first over exactly WIDTH enabled clocks with selectable fill.
module right_shifter #(
    parameter int WIDTH = 6,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FILL_ZERO  = 2'b00,
        FILL_ARITH = 2'b01,
        FILL_ROT   = 2'b10,
        FILL_SIN   = 2'b11
    } fill_t;

    state_t           state, state_n;
    fill_t            mode_r, mode_n;
    logic [WIDTH-1:0] q_n;
    logic             sout_n;
    logic [CW-1:0]    cnt_n;
    logic             fill;

    always_comb begin
        fill = 1'b0;
        case (mode_r)
            FILL_ZERO:  fill = 1'b0;
            FILL_ARITH: fill = q[WIDTH-1];
            FILL_ROT:   fill = q[0];
            FILL_SIN:   fill = sin;
            default:    fill = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        q_n     = q;
        sout_n  = sout;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (ld) begin
                    q_n     = d;
                    mode_n  = fill_t'(mode);
                    cnt_n   = CW'(WIDTH);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    sout_n = q[0];
                    q_n    = {fill, q[WIDTH-1:1]};
                    // Saturating decrement keeps cnt from wrapping if ever entered at zero.
                    cnt_n  = (cnt == '0) ? '0 : cnt - CW'(1);
                    if (cnt <= CW'(1))
                        state_n = DONE;
                end
            end
            DONE: begin
                if (ld) begin
                    q_n     = d;
                    mode_n  = fill_t'(mode);
                    cnt_n   = CW'(WIDTH);
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they align with q.
    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= IDLE;
            mode_r <= FILL_ZERO;
            q      <= '0;
            sout   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_r <= mode_n;
            q      <= q_n;
            sout   <= sout_n;
            cnt    <= cnt_n;
            busy   <= (state_n == SHIFT);
            done   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_right_shifter.sv
// Directed self-checking bench for right_shifter (WIDTH=6) covering all fill
// modes, stall, back-to-back load, ignored load and mid-shift clear.
module tb_right_shifter;

    localparam int WIDTH = 6;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             clear, ld, sin, en;
    logic [WIDTH-1:0] d;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;
    logic             sout, busy, done;
    logic [CW-1:0]    cnt;

    int checks = 0;
    int fails  = 0;

    right_shifter #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .clear(clear), .ld(ld), .d(d), .mode(mode), .sin(sin),
        .en(en), .q(q), .sout(sout), .busy(busy), .done(done), .cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [WIDTH-1:0] eq, input logic es,
                           input logic eb, input logic ed, input logic [CW-1:0] ec);
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".sout"}, 32'(sout), 32'(es));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".cnt"},  32'(cnt),  32'(ec));
    endtask

    logic [WIDTH-1:0] zq [6] = '{6'b010110, 6'b001011, 6'b000101, 6'b000010, 6'b000001, 6'b000000};
    logic             zs [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] aq [6] = '{6'b110010, 6'b111001, 6'b111100, 6'b111110, 6'b111111, 6'b111111};
    logic [WIDTH-1:0] rq [6] = '{6'b110000, 6'b011000, 6'b001100, 6'b000110, 6'b000011, 6'b100001};
    logic             sv [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] sq [6] = '{6'b100000, 6'b010000, 6'b101000, 6'b110100, 6'b011010, 6'b001101};

    initial begin
        clear = 1'b1; ld = 1'b0; d = '0; mode = 2'b00; sin = 1'b0; en = 1'b0;
        step();
        chk_all("reset", 6'b000000, 1'b0, 1'b0, 1'b0, 3'd0);

        // Zero fill
        clear = 1'b0; ld = 1'b1; d = 6'b101101; mode = 2'b00; en = 1'b1;
        step();
        chk_all("zero_load", 6'b101101, 1'b0, 1'b1, 1'b0, 3'd6);
        ld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk({"zero_q"},    32'(q),    32'(zq[i]));
            chk({"zero_sout"}, 32'(sout), 32'(zs[i]));
            chk({"zero_cnt"},  32'(cnt),  32'(5 - i));
            chk({"zero_done"}, 32'(done), (i == 5) ? 32'd1 : 32'd0);
            chk({"zero_busy"}, 32'(busy), (i == 5) ? 32'd0 : 32'd1);
        end
        step();
        chk_all("zero_idle", 6'b000000, 1'b1, 1'b0, 1'b0, 3'd0);

        // Arithmetic fill
        ld = 1'b1; d = 6'b100100; mode = 2'b01;
        step();
        chk_all("arith_load", 6'b100100, 1'b1, 1'b1, 1'b0, 3'd6);
        ld = 1'b0; mode = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("arith_q", 32'(q), 32'(aq[i]));
        end
        chk("arith_done", 32'(done), 32'd1);
        step();
        chk("arith_idle_done", 32'(done), 32'd0);

        // Rotate, then back-to-back load in the DONE cycle
        ld = 1'b1; d = 6'b100001; mode = 2'b10;
        step();
        ld = 1'b0; mode = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rot_q", 32'(q), 32'(rq[i]));
        end
        chk("rot_done", 32'(done), 32'd1);
        ld = 1'b1; d = 6'b000011; mode = 2'b00;
        step();
        chk_all("b2b_load", 6'b000011, 1'b1, 1'b1, 1'b0, 3'd6);
        ld = 1'b0;
        step();
        chk_all("b2b_shift1", 6'b000001, 1'b1, 1'b1, 1'b0, 3'd5);

        // Load request during SHIFT is ignored
        ld = 1'b1; d = 6'b111111; mode = 2'b11; sin = 1'b1;
        step();
        chk_all("ign_load", 6'b000000, 1'b1, 1'b1, 1'b0, 3'd4);

        // Clear with ld=1 mid-operation
        clear = 1'b1;
        step();
        chk_all("mid_clear", 6'b000000, 1'b0, 1'b0, 1'b0, 3'd0);
        clear = 1'b0; ld = 1'b0; mode = 2'b00; sin = 1'b0;
        step();
        chk_all("clear_idle", 6'b000000, 1'b0, 1'b0, 1'b0, 3'd0);

        // Serial-in with a 3-cycle stall after shift 2
        ld = 1'b1; d = 6'b000000; mode = 2'b11;
        step();
        ld = 1'b0; mode = 2'b00;
        for (int i = 0; i < 6; i++) begin
            sin = sv[i];
            en = 1'b1;
            step();
            chk("sin_q",   32'(q),   32'(sq[i]));
            chk("sin_cnt", 32'(cnt), 32'(5 - i));
            if (i == 1) begin
                en = 1'b0; sin = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk_all("stall", 6'b010000, 1'b0, 1'b1, 1'b0, 3'd4);
                end
            end
        end
        chk_all("sin_done", 6'b001101, 1'b0, 1'b0, 1'b1, 3'd0);
        en = 1'b0;
        step();
        chk_all("sin_idle", 6'b001101, 1'b0, 1'b0, 1'b0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
